spi_sample_engine: RTL and testbench
====================================

SPI_SAMPLE_ENGINE -- requirements
Module: spi_sample_engine

Interface
REQ-001 The block SHALL have parameter SAMPLE_W, default 16, meaning the ADC/DAC word width in bits.
REQ-002 The block SHALL have parameter CLK_DIV, default 4, meaning the number of clk cycles per sclk half-period (legal range 1..255).
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock; all logic is rising-edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 The block SHALL have port adc_clock, input, 1 bit: single-cycle sample strobe that starts one frame.
REQ-006 The block SHALL have port dac, input, SAMPLE_W bits: outgoing sample, latched on an accepted strobe.
REQ-007 The block SHALL have port miso, input, 1 bit: serial data from the ADC.
REQ-008 The block SHALL have port mosi, output, 1 bit: serial data to the DAC, MSB first.
REQ-009 The block SHALL have port sclk, output, 1 bit: SPI clock, mode 0 (idle low).
REQ-010 The block SHALL have port cs, output, 1 bit: chip select, active-low.
REQ-011 The block SHALL have port adc, output, SAMPLE_W bits: last completed captured sample.
REQ-012 The block SHALL have port adc_valid, output, 1 bit: one-cycle pulse when adc updates.
REQ-013 The block SHALL have port busy, output, 1 bit: high from strobe acceptance until the frame completes.
REQ-014 The block SHALL have port overrun, output, 1 bit: sticky flag, set when a strobe arrives while busy.

Function
REQ-015 The FSM SHALL have states IDLE, SETUP, SHIFT_LO, SHIFT_HI, HOLD, DONE.
REQ-016 When adc_clock=1 in IDLE, the block SHALL latch dac into the tx shift register and enter SETUP on the next edge: cs=0, mosi=tx MSB, busy=1.
REQ-017 SETUP SHALL last CLK_DIV cycles with sclk=0, then go to SHIFT_LO.
REQ-018 SHIFT_LO SHALL hold sclk=0 for CLK_DIV cycles, then enter SHIFT_HI; SHIFT_HI SHALL hold sclk=1 for CLK_DIV cycles.
REQ-019 miso SHALL be sampled into the rx shift register (MSB first) on the clk edge entering SHIFT_HI.
REQ-020 mosi SHALL advance to the next tx bit on the edge leaving SHIFT_HI, if bits remain.
REQ-021 A bit counter SHALL count SAMPLE_W high phases; after the last SHIFT_HI the FSM SHALL enter HOLD (sclk=0, cs=0) for CLK_DIV cycles.
REQ-022 In DONE (1 cycle), the block SHALL drive cs=1 and busy=0, load adc from rx, and pulse adc_valid=1; it SHALL then return to IDLE.
REQ-023 Frame length, strobe edge to adc_valid, SHALL equal CLK_DIV*(2*SAMPLE_W+2)+1 cycles (137 at defaults).
REQ-024 An adc_clock strobe while busy=1 (including the DONE cycle) SHALL be ignored, SHALL set overrun=1, and SHALL NOT disturb the frame in progress.
REQ-025 Changes on dac during a frame SHALL NOT affect mosi.
REQ-026 A strobe arriving in the first IDLE cycle after DONE SHALL be accepted normally.
REQ-027 The adc output SHALL hold its value between adc_valid pulses.

Reset
REQ-028 While rst=1, asynchronously: state=IDLE, cs=1, sclk=0, mosi=0, adc=0, adc_valid=0, busy=0, overrun=0, and counters and shift registers are cleared.
REQ-029 Reset asserted mid-frame SHALL abort the frame with no adc_valid pulse; the first strobe after release SHALL start a clean frame.

Structure
REQ-030 The shared package pedal_pkg SHALL hold the FSM state enum, SAMPLE_W default, and the CLK_DIV default.
REQ-031 The half-period tick counter SHALL be the sub-module spi_tick_gen (inputs clk, rst, enable; output tick every CLK_DIV cycles).

Verification
REQ-032 Bench SHALL cover loopback: miso tied to mosi, dac=16'hA5C3, strobe → adc=16'hA5C3 with adc_valid 137 cycles after strobe; cs low for exactly 136 cycles.
REQ-033 Bench SHALL cover constant input: miso=1, dac=16'h0000 → adc=16'hFFFF; mosi=0 throughout; exactly 16 sclk rising edges.
REQ-034 Bench SHALL cover overrun: a second strobe 50 cycles into a frame → overrun=1, frame completes at cycle 137, and no second frame starts.
REQ-035 Bench SHALL cover mid-frame reset: rst pulsed at cycle 70 → cs=1, sclk=0, busy=0 immediately, no adc_valid; the next strobe gives a correct frame.
REQ-036 Bench SHALL cover minimum divide: CLK_DIV=1, loopback 16'h8001 → adc=16'h8001 at cycle 35; sclk toggles every cycle.

Source files
------------

// File: rtl/spi_sample_engine_pkg.sv
// Shared types and defaults for the SPI sample engine: FSM state encoding
// and the default word width / clock divide.
package pedal_pkg;

   localparam int SAMPLE_W_DEF = 16;
   localparam int CLK_DIV_DEF  = 4;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      SHIFT_LO,
      SHIFT_HI,
      HOLD,
      DONE
   } state_e;

endpackage

// File: rtl/spi_sample_engine_if.sv
// Sample/serial bundle between the sample engine and its user: strobe, DAC
// word in, ADC word out, status flags and the three SPI wires.
interface spi_sample_engine_if import pedal_pkg::*; #(
   parameter int SAMPLE_W = SAMPLE_W_DEF
);

   logic                adc_clock;
   logic [SAMPLE_W-1:0] dac;
   logic                miso;
   logic                mosi;
   logic                sclk;
   logic                cs;
   logic [SAMPLE_W-1:0] adc;
   logic                adc_valid;
   logic                busy;
   logic                overrun;

   modport master (
      output adc_clock, dac, miso,
      input  mosi, sclk, cs, adc, adc_valid, busy, overrun
   );

   modport slave (
      input  adc_clock, dac, miso,
      output mosi, sclk, cs, adc, adc_valid, busy, overrun
   );

endinterface

// File: rtl/spi_sample_engine_tick.sv
// Half-period tick generator: while enabled, pulses tick once every CLK_DIV
// cycles; dropping enable restarts the count so each phase starts aligned.
module spi_tick_gen import pedal_pkg::*; #(
   parameter int CLK_DIV = CLK_DIV_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic enable,
   output logic tick
);

   localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

   logic [7:0] cnt_q;
   logic [7:0] cnt_d;

   assign tick = enable && (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q;
      if (!enable || tick) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/spi_sample_engine.sv
// Full-duplex SPI frame engine: one strobe shifts a DAC word out on mosi while
// capturing an ADC word from miso, mode 0, MSB first.
module spi_sample_engine import pedal_pkg::*; #(
   parameter int SAMPLE_W = SAMPLE_W_DEF,
   parameter int CLK_DIV  = CLK_DIV_DEF
) (
   input  logic               clk,
   input  logic               rst,
   spi_sample_engine_if.slave bus
);

   localparam int BW = (SAMPLE_W > 1) ? $clog2(SAMPLE_W) : 1;
   localparam logic [BW-1:0] LAST_BIT = BW'(SAMPLE_W - 1);

   state_e              state_q, state_d;
   logic [SAMPLE_W-1:0] tx_q, tx_d;
   logic [SAMPLE_W-1:0] rx_q, rx_d;
   logic [BW-1:0]       bit_cnt_q, bit_cnt_d;
   logic                mosi_q, mosi_d;
   logic                sclk_q, sclk_d;
   logic                cs_q, cs_d;
   logic [SAMPLE_W-1:0] adc_q, adc_d;
   logic                adc_valid_q, adc_valid_d;
   logic                busy_q, busy_d;
   logic                overrun_q, overrun_d;
   logic                tick;
   logic                tick_en;

   assign tick_en = (state_q == SETUP) || (state_q == SHIFT_LO) ||
                    (state_q == SHIFT_HI) || (state_q == HOLD);

   spi_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
      .clk    (clk),
      .rst    (rst),
      .enable (tick_en),
      .tick   (tick)
   );

   // DONE still counts as busy for strobes even though the busy output has dropped.
   always_comb begin
      state_d     = state_q;
      tx_d        = tx_q;
      rx_d        = rx_q;
      bit_cnt_d   = bit_cnt_q;
      mosi_d      = mosi_q;
      sclk_d      = sclk_q;
      cs_d        = cs_q;
      adc_d       = adc_q;
      adc_valid_d = 1'b0;
      busy_d      = busy_q;
      overrun_d   = overrun_q;

      if (bus.adc_clock && (state_q != IDLE)) begin
         overrun_d = 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (bus.adc_clock) begin
               state_d   = SETUP;
               tx_d      = bus.dac;
               mosi_d    = bus.dac[SAMPLE_W-1];
               rx_d      = '0;
               bit_cnt_d = '0;
               cs_d      = 1'b0;
               busy_d    = 1'b1;
            end
         end
         SETUP: begin
            if (tick) begin
               state_d = SHIFT_LO;
            end
         end
         SHIFT_LO: begin
            if (tick) begin
               state_d = SHIFT_HI;
               sclk_d  = 1'b1;
               rx_d    = {rx_q[SAMPLE_W-2:0], bus.miso};
            end
         end
         SHIFT_HI: begin
            if (tick) begin
               sclk_d = 1'b0;
               if (bit_cnt_q == LAST_BIT) begin
                  state_d = HOLD;
               end else begin
                  state_d   = SHIFT_LO;
                  bit_cnt_d = bit_cnt_q + 1'b1;
                  tx_d      = tx_q << 1;
                  mosi_d    = tx_q[SAMPLE_W-2];
               end
            end
         end
         HOLD: begin
            if (tick) begin
               state_d     = DONE;
               cs_d        = 1'b1;
               busy_d      = 1'b0;
               mosi_d      = 1'b0;
               adc_d       = rx_q;
               adc_valid_d = 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         tx_q        <= '0;
         rx_q        <= '0;
         bit_cnt_q   <= '0;
         mosi_q      <= 1'b0;
         sclk_q      <= 1'b0;
         cs_q        <= 1'b1;
         adc_q       <= '0;
         adc_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         tx_q        <= tx_d;
         rx_q        <= rx_d;
         bit_cnt_q   <= bit_cnt_d;
         mosi_q      <= mosi_d;
         sclk_q      <= sclk_d;
         cs_q        <= cs_d;
         adc_q       <= adc_d;
         adc_valid_q <= adc_valid_d;
         busy_q      <= busy_d;
         overrun_q   <= overrun_d;
      end
   end

   assign bus.mosi      = mosi_q;
   assign bus.sclk      = sclk_q;
   assign bus.cs        = cs_q;
   assign bus.adc       = adc_q;
   assign bus.adc_valid = adc_valid_q;
   assign bus.busy      = busy_q;
   assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_spi_sample_engine.sv
// Directed bench for spi_sample_engine: default-divide instance plus a
// CLK_DIV=1 instance, frames timed against hand-computed expectations.
module tb_spi_sample_engine;
   import pedal_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic sel = 1'b0;
   logic loop_en = 1'b0;
   logic miso_val = 1'b0;

   int checks = 0;
   int errors = 0;

   spi_sample_engine_if #(.SAMPLE_W(16)) bus0 ();
   spi_sample_engine_if #(.SAMPLE_W(16)) bus1 ();

   spi_sample_engine #(.SAMPLE_W(16), .CLK_DIV(4)) dut0 (
      .clk (clk),
      .rst (rst),
      .bus (bus0.slave)
   );

   spi_sample_engine #(.SAMPLE_W(16), .CLK_DIV(1)) dut1 (
      .clk (clk),
      .rst (rst),
      .bus (bus1.slave)
   );

   always #5 clk = ~clk;

   assign bus0.miso = loop_en ? bus0.mosi : miso_val;
   assign bus1.miso = loop_en ? bus1.mosi : miso_val;

   logic        v_sclk, v_cs, v_mosi, v_valid;
   logic [15:0] v_adc;
   assign v_sclk  = sel ? bus1.sclk      : bus0.sclk;
   assign v_cs    = sel ? bus1.cs        : bus0.cs;
   assign v_mosi  = sel ? bus1.mosi      : bus0.mosi;
   assign v_valid = sel ? bus1.adc_valid : bus0.adc_valid;
   assign v_adc   = sel ? bus1.adc       : bus0.adc;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic setStrobe(input logic v);
      if (sel) bus1.adc_clock = v;
      else     bus0.adc_clock = v;
   endtask

   task automatic setDac(input logic [15:0] v);
      if (sel) bus1.dac = v;
      else     bus0.dac = v;
   endtask

   // Runs one frame on the selected instance; latency counts edges from the
   // strobe being raised to the first sample showing adc_valid.
   task automatic applyStimulus(input logic [15:0] dac_v, input logic loop, input logic miso_v,
                                input int second_at, output int lat, output int cs_low,
                                output int rises, output int toggles, output int tog_span,
                                output int mosi_hi);
      logic prev;
      int   first_t;
      int   last_t;
      loop_en  = loop;
      miso_val = miso_v;
      lat = 0; cs_low = 0; rises = 0; toggles = 0; mosi_hi = 0;
      first_t = -1; last_t = -1;
      @(posedge clk); #1;
      setDac(dac_v);
      setStrobe(1'b1);
      prev = v_sclk;
      while (lat < 400) begin
         @(posedge clk); #1;
         lat++;
         setStrobe(lat == second_at);
         if (lat == 10) setDac(~dac_v);
         if (!v_cs) cs_low++;
         if (v_mosi) mosi_hi++;
         if (v_sclk && !prev) rises++;
         if (v_sclk != prev) begin
            toggles++;
            if (first_t < 0) first_t = lat;
            last_t = lat;
         end
         prev = v_sclk;
         if (v_valid) break;
      end
      setStrobe(1'b0);
      tog_span = last_t - first_t;
   endtask

   initial begin
      int lat, cs_low, rises, toggles, span, mosi_hi, cnt;

      bus0.adc_clock = 1'b0; bus0.dac = '0;
      bus1.adc_clock = 1'b0; bus1.dac = '0;

      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_cs",      32'(bus0.cs),        32'h1);
      checkOutput("rst_sclk",    32'(bus0.sclk),      32'h0);
      checkOutput("rst_mosi",    32'(bus0.mosi),      32'h0);
      checkOutput("rst_busy",    32'(bus0.busy),      32'h0);
      checkOutput("rst_adc",     32'(bus0.adc),       32'h0);
      checkOutput("rst_valid",   32'(bus0.adc_valid), 32'h0);
      checkOutput("rst_overrun", 32'(bus0.overrun),   32'h0);
      rst = 1'b0;

      sel = 1'b0;
      applyStimulus(16'hA5C3, 1'b1, 1'b0, 0, lat, cs_low, rises, toggles, span, mosi_hi);
      checkOutput("loop_latency", 32'(lat),    32'd137);
      checkOutput("loop_adc",     32'(v_adc),  32'hA5C3);
      checkOutput("loop_cs_low",  32'(cs_low), 32'd136);
      checkOutput("loop_rises",   32'(rises),  32'd16);

      applyStimulus(16'h0000, 1'b0, 1'b1, 0, lat, cs_low, rises, toggles, span, mosi_hi);
      checkOutput("const_latency", 32'(lat),          32'd137);
      checkOutput("const_adc",     32'(v_adc),        32'hFFFF);
      checkOutput("const_mosi_hi", 32'(mosi_hi),      32'd0);
      checkOutput("const_rises",   32'(rises),        32'd16);
      checkOutput("b2b_overrun",   32'(bus0.overrun), 32'h0);

      cnt = 0;
      repeat (5) begin
         @(posedge clk); #1;
         if (bus0.adc_valid) cnt++;
      end
      checkOutput("hold_adc",   32'(bus0.adc), 32'hFFFF);
      checkOutput("hold_valid", 32'(cnt),      32'd0);

      applyStimulus(16'h1234, 1'b1, 1'b0, 50, lat, cs_low, rises, toggles, span, mosi_hi);
      checkOutput("ovr_latency", 32'(lat),          32'd137);
      checkOutput("ovr_adc",     32'(v_adc),        32'h1234);
      checkOutput("ovr_flag",    32'(bus0.overrun), 32'h1);
      cnt = 0;
      repeat (150) begin
         @(posedge clk); #1;
         if (bus0.busy || !bus0.cs) cnt++;
      end
      checkOutput("ovr_no_second", 32'(cnt), 32'd0);

      @(posedge clk); #1;
      bus0.dac = 16'hC33C;
      bus0.adc_clock = 1'b1;
      @(posedge clk); #1;
      bus0.adc_clock = 1'b0;
      repeat (68) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      checkOutput("mrst_cs",      32'(bus0.cs),      32'h1);
      checkOutput("mrst_sclk",    32'(bus0.sclk),    32'h0);
      checkOutput("mrst_busy",    32'(bus0.busy),    32'h0);
      checkOutput("mrst_overrun", 32'(bus0.overrun), 32'h0);
      checkOutput("mrst_adc",     32'(bus0.adc),     32'h0);
      @(posedge clk); #1;
      rst = 1'b0;
      cnt = 0;
      repeat (160) begin
         @(posedge clk); #1;
         if (bus0.adc_valid) cnt++;
      end
      checkOutput("mrst_no_valid", 32'(cnt), 32'd0);

      applyStimulus(16'h5A5A, 1'b1, 1'b0, 0, lat, cs_low, rises, toggles, span, mosi_hi);
      checkOutput("clean_latency", 32'(lat),   32'd137);
      checkOutput("clean_adc",     32'(v_adc), 32'h5A5A);

      sel = 1'b1;
      applyStimulus(16'h8001, 1'b1, 1'b0, 0, lat, cs_low, rises, toggles, span, mosi_hi);
      checkOutput("div1_latency", 32'(lat),     32'd35);
      checkOutput("div1_adc",     32'(v_adc),   32'h8001);
      checkOutput("div1_rises",   32'(rises),   32'd16);
      checkOutput("div1_toggles", 32'(toggles), 32'd32);
      checkOutput("div1_span",    32'(span),    32'd31);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
